// File: rtl/detector_tur.sv
// Start/finish-line lap detector: synchronizes and debounces the line sensor,
// emits one pulse per lap, enforces a minimum lap time and measures lap length.
module detector_tur #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 50000
) (
  input  logic        tact,
  input  logic        reset,
  input  logic        senzor_start,
  input  logic        enable,
  output logic        puls_tur,
  output logic [15:0] timp_tur,
  output logic        tur_valid,
  output logic        pe_marcaj
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEB, MARK, LOCK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [15:0]   cnt_tur_q, cnt_tur_d;
  logic [15:0]   timp_q, timp_d;
  logic          valid_q, valid_d;
  logic          first_q, first_d;
  logic          puls_q, puls_d;
  logic          marcaj_q, marcaj_d;
  logic          s_sync;

  assign s_sync = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], senzor_start};
    state_d   = state_q;
    deb_d     = deb_q;
    lock_d    = lock_q;
    cnt_tur_d = cnt_tur_q;
    timp_d    = timp_q;
    valid_d   = valid_q;
    first_d   = first_q;
    puls_d    = 1'b0;

    if (enable) begin
      if (cnt_tur_q != 16'hFFFF) cnt_tur_d = cnt_tur_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (s_sync) begin
            state_d = DEB;
            deb_d   = DW'(1);
          end
        end
        DEB: begin
          if (!s_sync) begin
            state_d = IDLE;
            deb_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            puls_d  = 1'b1;
            state_d = MARK;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + DW'(1);
          end
        end
        MARK: begin
          if (!s_sync) begin
            state_d = LOCK;
            lock_d  = '0;
          end
        end
        default: begin
          if (lock_q == LOCK_LAST) begin
            state_d = IDLE;
            lock_d  = '0;
          end else begin
            lock_d = lock_q + LW'(1);
          end
        end
      endcase

      // cnt_tur restarts at 1 so its value at the next pulse edge equals the
      // number of enabled cycles between the two pulses.
      if (puls_d) begin
        if (first_q) begin
          timp_d  = cnt_tur_q;
          valid_d = 1'b1;
        end
        first_d   = 1'b1;
        cnt_tur_d = 16'd1;
      end
    end else begin
      state_d = IDLE;
      deb_d   = '0;
      lock_d  = '0;
    end

    marcaj_d = (state_d == MARK);
  end

  always_ff @(posedge tact) begin
    if (reset) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      deb_q     <= '0;
      lock_q    <= '0;
      cnt_tur_q <= '0;
      timp_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      puls_q    <= 1'b0;
      marcaj_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      lock_q    <= lock_d;
      cnt_tur_q <= cnt_tur_d;
      timp_q    <= timp_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      puls_q    <= puls_d;
      marcaj_q  <= marcaj_d;
    end
  end

  assign puls_tur  = puls_q;
  assign timp_tur  = timp_q;
  assign tur_valid = valid_q;
  assign pe_marcaj = marcaj_q;

endmodule
